// File: rtl/if_fetch_queue_if.sv
// Bus and pipeline-control bundle for the IF fetch queue.
// The master side is the queue itself; the slave side is the bus/controller environment.
interface if_fetch_queue_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_req;
  logic [DATA_W-1:0] insn;
  logic              fetch_rdy;
  logic              stall;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic              br_taken;
  logic [ADDR_W-1:0] br_addr;
  logic [ADDR_W-1:0] if_pc;
  logic [DATA_W-1:0] if_insn;
  logic              if_en;
  logic [OCC_W-1:0]  occupancy;
  logic              full;

  modport master (
    output fetch_addr, fetch_req, if_pc, if_insn, if_en, occupancy, full,
    input  insn, fetch_rdy, stall, flush, new_pc, br_taken, br_addr
  );

  modport slave (
    input  fetch_addr, fetch_req, if_pc, if_insn, if_en, occupancy, full,
    output insn, fetch_rdy, stall, flush, new_pc, br_taken, br_addr
  );
endinterface

// File: rtl/if_fetch_queue.sv
// IF-stage fetch queue: owns the fetch PC, buffers fetched {pc, insn} pairs in a
// circular store and presents the oldest one to ID as the IF/ID register.
module if_fetch_queue #(
  parameter int                   ADDR_W       = 30,
  parameter int                   DATA_W       = 32,
  parameter int                   DEPTH        = 4,
  parameter logic [ADDR_W-1:0]    RESET_VECTOR = '0,
  parameter logic [DATA_W-1:0]    NOP_INSN     = '0
) (
  input  logic                clk,
  input  logic                reset,
  if_fetch_queue_if.master    bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [OCC_W-1:0]  r_occ;
  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [DATA_W-1:0] r_insn_mem [DEPTH];

  logic              w_full;
  logic              w_fetch_req;
  logic              w_if_en;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_target;
  logic              w_push;
  logic              w_pop;

  assign w_full      = (r_occ == OCC_W'(DEPTH));
  assign w_fetch_req = !w_full;
  assign w_if_en     = (r_occ != '0);

  // A stalled ID stage freezes the pipeline, so redirects wait until it releases.
  assign w_redirect = !bus.stall && (bus.flush || bus.br_taken);
  assign w_target   = bus.flush ? bus.new_pc : bus.br_addr;
  assign w_push     = w_fetch_req && bus.fetch_rdy && !w_redirect;
  assign w_pop      = !bus.stall && w_if_en && !w_redirect;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_VECTOR;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_occ      <= '0;
    end else if (w_redirect) begin
      r_fetch_pc <= w_target;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_occ      <= '0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
        r_wptr     <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Storage carries no reset; entries are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wptr]   <= r_fetch_pc;
      r_insn_mem[r_wptr] <= bus.insn;
    end
  end

  assign bus.fetch_addr = r_fetch_pc;
  assign bus.fetch_req  = w_fetch_req;
  assign bus.full       = w_full;
  assign bus.occupancy  = r_occ;
  assign bus.if_en      = w_if_en;
  assign bus.if_pc      = w_if_en ? r_pc_mem[r_rptr]   : r_fetch_pc;
  assign bus.if_insn    = w_if_en ? r_insn_mem[r_rptr] : NOP_INSN;
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: two configurations (DEPTH=4/ADDR_W=30 and DEPTH=8/ADDR_W=16)
// share one stimulus stream and are compared every cycle against a list-based queue model.
module tb_if_fetch_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_rdy, stall, flush, br_taken;
  logic [29:0] new_pc, br_addr;
  logic [31:0] insn;

  int n_chk = 0;
  int n_err = 0;

  if_fetch_queue_if #(.ADDR_W(30), .DATA_W(32), .DEPTH(4)) b0 ();
  if_fetch_queue_if #(.ADDR_W(16), .DATA_W(32), .DEPTH(8)) b1 ();

  assign b0.insn      = insn;
  assign b0.fetch_rdy = fetch_rdy;
  assign b0.stall     = stall;
  assign b0.flush     = flush;
  assign b0.new_pc    = new_pc;
  assign b0.br_taken  = br_taken;
  assign b0.br_addr   = br_addr;
  assign b1.insn      = insn;
  assign b1.fetch_rdy = fetch_rdy;
  assign b1.stall     = stall;
  assign b1.flush     = flush;
  assign b1.new_pc    = new_pc[15:0];
  assign b1.br_taken  = br_taken;
  assign b1.br_addr   = br_addr[15:0];

  if_fetch_queue #(.ADDR_W(30), .DATA_W(32), .DEPTH(4), .RESET_VECTOR(30'h0), .NOP_INSN(32'h0))
    dut0 (.clk(clk), .reset(reset), .bus(b0));
  if_fetch_queue #(.ADDR_W(16), .DATA_W(32), .DEPTH(8), .RESET_VECTOR(16'h0), .NOP_INSN(32'h0))
    dut1 (.clk(clk), .reset(reset), .bus(b1));

  always #5 clk = ~clk;

  // Reference model: an ordered list per configuration, head at index 0.
  logic [31:0] m_pc  [2][8];
  logic [31:0] m_in  [2][8];
  int          m_cnt [2] = '{0, 0};
  logic [31:0] m_fpc [2] = '{32'h0, 32'h0};

  function automatic int dep(int i);
    return (i == 0) ? 4 : 8;
  endfunction

  function automatic logic [31:0] amask(int i);
    return (i == 0) ? 32'h3FFF_FFFF : 32'h0000_FFFF;
  endfunction

  task automatic model_step(int i);
    logic redir, pop, push;
    logic [31:0] tgt;
    redir = !stall && (flush || br_taken);
    tgt   = (flush ? {2'b00, new_pc} : {2'b00, br_addr}) & amask(i);
    pop   = !stall && (m_cnt[i] != 0) && !redir;
    push  = (m_cnt[i] != dep(i)) && fetch_rdy && !redir;
    if (redir) begin
      m_cnt[i] = 0;
      m_fpc[i] = tgt;
    end else begin
      if (pop) begin
        for (int j = 0; j < 7; j++) begin
          m_pc[i][j] = m_pc[i][j+1];
          m_in[i][j] = m_in[i][j+1];
        end
        m_cnt[i] = m_cnt[i] - 1;
      end
      if (push) begin
        m_pc[i][m_cnt[i]] = m_fpc[i];
        m_in[i][m_cnt[i]] = insn;
        m_cnt[i] = m_cnt[i] + 1;
        m_fpc[i] = (m_fpc[i] + 32'd1) & amask(i);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        for (int i = 0; i < 2; i++) begin
          m_cnt[i] = 0;
          m_fpc[i] = 32'h0;
        end
      end else begin
        model_step(0);
        model_step(1);
      end
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(int i, logic [63:0] fa, logic fr, logic [63:0] pc,
                          logic [63:0] ins, logic en, logic [63:0] occ, logic fl);
    logic [31:0] e_pc, e_in;
    e_pc = (m_cnt[i] != 0) ? m_pc[i][0] : m_fpc[i];
    e_in = (m_cnt[i] != 0) ? m_in[i][0] : 32'h0;
    chk($sformatf("m%0d.fetch_addr", i), fa, 64'(m_fpc[i]));
    chk($sformatf("m%0d.fetch_req", i), 64'(fr), 64'(m_cnt[i] != dep(i)));
    chk($sformatf("m%0d.if_pc", i), pc, 64'(e_pc));
    chk($sformatf("m%0d.if_insn", i), ins, 64'(e_in));
    chk($sformatf("m%0d.if_en", i), 64'(en), 64'(m_cnt[i] != 0));
    chk($sformatf("m%0d.occupancy", i), occ, 64'(m_cnt[i]));
    chk($sformatf("m%0d.full", i), 64'(fl), 64'(m_cnt[i] == dep(i)));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp_inst(0, 64'(b0.fetch_addr), b0.fetch_req, 64'(b0.if_pc), 64'(b0.if_insn),
               b0.if_en, 64'(b0.occupancy), b0.full);
      cmp_inst(1, 64'(b1.fetch_addr), b1.fetch_req, 64'(b1.if_pc), 64'(b1.if_insn),
               b1.if_en, 64'(b1.occupancy), b1.full);
    end
  end

  // Advance one clock; the bus answers each fetch with 32'h1000_0000 + address.
  task automatic cyc();
    @(posedge clk);
    #1;
    insn = 32'h1000_0000 + 32'(b0.fetch_addr);
  endtask

  initial begin
    reset = 1'b1; fetch_rdy = 1'b0; stall = 1'b0; flush = 1'b0; br_taken = 1'b0;
    new_pc = '0; br_addr = '0; insn = 32'h1000_0000;
    #1 reset = 1'b0;
    cyc(); cyc();
    chk("rst.if_en", 64'(b0.if_en), 64'd0);
    chk("rst.if_insn", 64'(b0.if_insn), 64'd0);
    chk("rst.if_pc", 64'(b0.if_pc), 64'd0);
    chk("rst.fetch_addr", 64'(b0.fetch_addr), 64'd0);
    chk("rst.fetch_req", 64'(b0.fetch_req), 64'd1);
    chk("rst.full", 64'(b0.full), 64'd0);
    chk("rst.occupancy", 64'(b0.occupancy), 64'd0);

    reset = 1'b1; fetch_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("steady.if_en", 64'(b0.if_en), 64'd1);
      chk("steady.if_pc", 64'(b0.if_pc), 64'(k));
      chk("steady.if_insn", 64'(b0.if_insn), 64'(32'h1000_0000 + k));
      chk("steady.occupancy", 64'(b0.occupancy), 64'd1);
    end

    stall = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk("stall.occupancy", 64'(b0.occupancy), 64'((k + 1 > 4) ? 4 : k + 1));
    end
    chk("stall.full", 64'(b0.full), 64'd1);
    chk("stall.fetch_req", 64'(b0.fetch_req), 64'd0);
    chk("stall.fetch_addr", 64'(b0.fetch_addr), 64'd7);
    chk("stall.if_pc", 64'(b0.if_pc), 64'd3);

    stall = 1'b0; fetch_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("drain.if_pc", 64'(b0.if_pc), 64'(4 + k));
      chk("drain.occupancy", 64'(b0.occupancy), 64'(3 - k));
    end
    cyc();
    chk("drain.if_en", 64'(b0.if_en), 64'd0);
    chk("drain.if_pc_empty", 64'(b0.if_pc), 64'd7);
    chk("drain.if_insn_nop", 64'(b0.if_insn), 64'd0);

    stall = 1'b1; fetch_rdy = 1'b1;
    repeat (4) cyc();
    chk("fill.occupancy", 64'(b0.occupancy), 64'd4);
    chk("fill.fetch_addr", 64'(b0.fetch_addr), 64'd11);

    stall = 1'b0; flush = 1'b1; new_pc = 30'h100;
    cyc();
    flush = 1'b0;
    chk("flush.occupancy", 64'(b0.occupancy), 64'd0);
    chk("flush.if_en", 64'(b0.if_en), 64'd0);
    chk("flush.fetch_addr", 64'(b0.fetch_addr), 64'h100);
    chk("flush.fetch_req", 64'(b0.fetch_req), 64'd1);
    cyc();
    chk("flush.first_pc", 64'(b0.if_pc), 64'h100);
    chk("flush.first_insn", 64'(b0.if_insn), 64'h1000_0100);
    chk("flush.first_occ", 64'(b0.occupancy), 64'd1);

    flush = 1'b1; br_taken = 1'b1; new_pc = 30'h200; br_addr = 30'h300;
    cyc();
    chk("prio.fetch_addr", 64'(b0.fetch_addr), 64'h200);
    chk("prio.occupancy", 64'(b0.occupancy), 64'd0);
    flush = 1'b0; br_taken = 1'b0;
    cyc();
    chk("prio.if_pc", 64'(b0.if_pc), 64'h200);

    stall = 1'b1; fetch_rdy = 1'b0; flush = 1'b1; br_taken = 1'b1;
    new_pc = 30'h50; br_addr = 30'h60;
    cyc();
    chk("stallredir.occupancy", 64'(b0.occupancy), 64'd1);
    chk("stallredir.if_pc", 64'(b0.if_pc), 64'h200);
    chk("stallredir.fetch_addr", 64'(b0.fetch_addr), 64'h201);

    stall = 1'b0; br_taken = 1'b0; new_pc = 30'h3FFF_FFFF;
    cyc();
    flush = 1'b0;
    chk("wrap.top0", 64'(b0.fetch_addr), 64'h3FFF_FFFF);
    chk("wrap.top1", 64'(b1.fetch_addr), 64'hFFFF);
    stall = 1'b1; fetch_rdy = 1'b1;
    cyc();
    chk("wrap.addr0", 64'(b0.fetch_addr), 64'd0);
    chk("wrap.addr1", 64'(b1.fetch_addr), 64'd0);
    chk("wrap.if_pc", 64'(b0.if_pc), 64'h3FFF_FFFF);
    chk("wrap.if_insn", 64'(b0.if_insn), 64'h4FFF_FFFF);
    stall = 1'b0;
    repeat (10) cyc();
    chk("wrap.steady_occ", 64'(b0.occupancy), 64'd1);

    stall = 1'b1;
    cyc(); cyc();
    chk("midrst.pre_occ", 64'(b0.occupancy), 64'd3);
    #2 reset = 1'b0;
    #1;
    chk("midrst.if_en", 64'(b0.if_en), 64'd0);
    chk("midrst.fetch_addr", 64'(b0.fetch_addr), 64'd0);
    chk("midrst.occupancy", 64'(b0.occupancy), 64'd0);
    chk("midrst.if_insn", 64'(b0.if_insn), 64'd0);
    chk("midrst.fetch_req", 64'(b0.fetch_req), 64'd1);
    chk("midrst.occ1", 64'(b1.occupancy), 64'd0);
    cyc();
    reset = 1'b1;

    for (int k = 0; k < 400; k++) begin
      fetch_rdy = ($urandom % 4) != 0;
      stall     = ($urandom % 3) == 0;
      flush     = ($urandom % 16) == 0;
      br_taken  = ($urandom % 12) == 0;
      new_pc    = 30'($urandom);
      br_addr   = 30'($urandom);
      cyc();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
